// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Constants and types shared by the pipelined LEGv8 front end.
//                Holds the default PC width, the instruction width, the
//                canonical NOP encoding, the bounds of the two branch
//                immediate fields, and the per-edge fetch operation type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int PC_W_DEF = 64;
   localparam int INSTR_W  = 32;

   // ADDI XZR, XZR, #0 : architecturally a no-op, used for pipeline bubbles
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h910003FF;

   // B / BL immediate field
   localparam int IMM26_MSB = 25;
   localparam int IMM26_LSB = 0;
   localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;

   // CBZ / B.cond immediate field
   localparam int IMM19_MSB = 23;
   localparam int IMM19_LSB = 5;
   localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

   // What the fetch stage does on the coming clock edge
   typedef enum logic [1:0] {
      FETCH_HOLD     = 2'd0,
      FETCH_REDIRECT = 2'd1,
      FETCH_SEQ      = 2'd2
   } fetch_op_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_calc
//  Description : Purely combinational branch target generator.
//                target = pc + (sext(imm) << 2), modulo 2^PC_W.
//                uncond_br = 1 selects imm26 (instr[25:0]),
//                uncond_br = 0 selects imm19 (instr[23:5]).
//  Revision    : 1.0 - initial release
//
//  Ports
//    instr      in  32    instruction currently held in IF/ID
//    pc         in  PC_W  PC of that instruction
//    uncond_br  in  1     1 = unconditional branch immediate format
//    target     out PC_W  computed branch target
// ============================================================================
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [PC_W-1:0]    pc,
   input  logic               uncond_br,
   output logic [PC_W-1:0]    target
);

   // Width used for sign extension: wide enough for the shifted imm26 and
   // for the PC itself; the result is then truncated to PC_W so that narrow
   // PCs wrap naturally.
   localparam int EXT_W = (PC_W > IMM26_W + 2) ? PC_W : IMM26_W + 2;

   logic signed [IMM26_W+1:0] w_off26;
   logic signed [IMM19_W+1:0] w_off19;
   logic signed [EXT_W-1:0]   w_ext26;
   logic signed [EXT_W-1:0]   w_ext19;
   logic [PC_W-1:0]           w_off;
   logic                      w_unused_opcode;

   // Word offsets: the immediate is in instructions, so append two zeros
   assign w_off26 = {instr[IMM26_MSB:IMM26_LSB], 2'b00};
   assign w_off19 = {instr[IMM19_MSB:IMM19_LSB], 2'b00};

   // Signed size casts sign-extend
   assign w_ext26 = EXT_W'(w_off26);
   assign w_ext19 = EXT_W'(w_off19);

   assign w_off  = uncond_br ? w_ext26[PC_W-1:0] : w_ext19[PC_W-1:0];
   assign target = pc + w_off;

   // Opcode bits are decoded elsewhere; they do not affect the target
   assign w_unused_opcode = ^instr[INSTR_W-1:IMM26_MSB+1];

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage plus IF/ID pipeline register of the pipelined
//                LEGv8 core. Owns the PC, addresses instruction memory,
//                registers the fetched word with its PC for decode, and
//                redirects fetch when the decoder resolves a taken branch
//                held in IF/ID.
//  Revision    : 1.0 - initial release
//
//  Build option
//    FETCH_DELAY_SLOT_EN  defined   : the instruction fetched in the
//                                     redirect cycle is kept (delay slot),
//                                     0-bubble branch penalty.
//                         undefined : that instruction is squashed into a
//                                     bubble, 1-bubble branch penalty.
//
//  Parameters
//    PC_W      PC / address width
//    RESET_PC  PC loaded on reset
//
//  Ports
//    clk          in  1     clock, rising edge
//    reset        in  1     asynchronous active-high reset
//    stall        in  1     load-use stall, freezes PC and IF/ID
//    br_taken     in  1     branch taken, decoded from if_id_instr
//    uncond_br    in  1     immediate format select for the target
//    imem_data    in  32    instruction word at imem_addr
//    imem_addr    out PC_W  current PC register
//    if_id_instr  out 32    instruction for ID
//    if_id_pc     out PC_W  PC of if_id_instr
//    if_id_valid  out 1     1 = real instruction, 0 = bubble
// ============================================================================
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               br_taken,
   input  logic               uncond_br,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [PC_W-1:0]    imem_addr,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [PC_W-1:0]    if_id_pc,
   output logic               if_id_valid
);

   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_if_pc;
   logic               r_valid;

   logic [PC_W-1:0]    w_target;
   fetch_op_e          w_op;

   branch_target_calc #(
      .PC_W      (PC_W)
   ) u_target (
      .instr     (r_instr),
      .pc        (r_if_pc),
      .uncond_br (uncond_br),
      .target    (w_target)
   );

   // Stall wins over everything, so a branch seen during a stall is simply
   // re-evaluated once the stall drops. A bubble in IF/ID never redirects,
   // whatever the decoder says about the NOP.
   always_comb begin
      w_op = FETCH_SEQ;
      if (stall) begin
         w_op = FETCH_HOLD;
      end else if (br_taken && r_valid) begin
         w_op = FETCH_REDIRECT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_if_pc <= '0;
         r_valid <= 1'b0;
      end else begin
         case (w_op)
            FETCH_REDIRECT: begin
               r_pc    <= w_target;
               r_if_pc <= r_pc;
`ifdef FETCH_DELAY_SLOT_EN
               // Delay slot: the sequential instruction still executes
               r_instr <= imem_data;
               r_valid <= 1'b1;
`else
               // Wrong-path instruction is squashed
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
`endif
            end
            FETCH_SEQ: begin
               r_pc    <= r_pc + PC_W'(4);
               r_instr <= imem_data;
               r_if_pc <= r_pc;
               r_valid <= 1'b1;
            end
            default: begin
               // FETCH_HOLD: all state frozen
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign if_id_instr = r_instr;
   assign if_id_pc    = r_if_pc;
   assign if_id_valid = r_valid;

endmodule : fetch_stage
`default_nettype wire
